mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit; consumes the 6-bit ALU function code from the ALU control decoder.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
//  Holds architectural HI/LO; MFHI/MFLO read hi/lo directly. Core stalls its pipeline while busy=1.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are WIDTH bits each
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous active-low reset
//  start    in   1      issue strobe; fncode/op_a/op_b valid this cycle
//  fncode   in   6      function code: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
//  op_a     in   WIDTH  rs value: multiplicand / dividend / MTHI,MTLO data
//  op_b     in   WIDTH  rt value: multiplier / divisor
//  busy     out  1      high while a MULT/MULTU/DIV/DIVU is in flight
//  done     out  1      one-cycle pulse, coincident with updated hi/lo
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and datapath cleared. Takes effect immediately, including mid-operation; partial result discarded.
//  - FSM states:
//    - IDLE: accept start.
//    - RUN: WIDTH iterations, counter WIDTH..1.
//    - FIX: sign correction; write HI/LO; back to IDLE.
//  - busy = (state != IDLE), combinational from state.
//  - Start acceptance:
//    - start accepted only in IDLE. start while busy is ignored (no effect on state, hi or lo).
//    - start with any fncode outside the listed set: ignored, no done.
//    - start with MFHI/MFLO: no state change, no done.
//  - MTHI/MTLO: on the accept edge hi (resp. lo) <= op_a; done=1 in the next cycle; busy stays 0.
//  - MULT/MULTU/DIV/DIVU latency: accept edge -> RUN for WIDTH cycles -> FIX for 1 cycle -> IDLE.
//    - busy is high for exactly WIDTH+1 cycles.
//    - hi/lo update and done=1 occur WIDTH+2 cycles after the accept edge; first cycle back in IDLE, so a new start is accepted that same cycle.
//  - Multiply: shift-add over |a|,|b| (signed) or a,b (unsigned).
//    - 2*WIDTH-bit product; {hi,lo} = product.
//    - Signed: product negated in FIX when sign(a)^sign(b).
//  - Divide: radix-2 restoring over magnitudes; lo=quotient, hi=remainder.
//    - Signed: quotient negated when sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
//    - Overflow, signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (magnitude arithmetic wraps naturally; no special case).
//    - Divide by zero, DIVU: lo=all-ones, hi=op_a.
//    - Divide by zero, DIV: lo=all-ones, hi=op_a. Full latency still taken.
//  - Operands are latched on the accept edge; op_a/op_b/fncode changes during RUN have no effect.
//  - done is registered, high for exactly one cycle per completed operation.
// CONFIGURATION
//  - FAST_MULT_EN defined:
//    - MULT/MULTU use a single-cycle combinational WIDTHxWIDTH multiplier.
//    - hi/lo written on the accept edge; done=1 the following cycle; busy never asserted for multiplies.
//    - Divide is unchanged.
//  - FAST_MULT_EN undefined: iterative multiply as above (WIDTH+2 latency).
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done at cycle 34.
//     With FAST_MULT_EN: done at cycle 1, busy never high.
//  2. MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
//  3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
//  4. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; no hang, done pulses once.
//  5. Short ops and ignored starts:
//     - MTHI 0x12345678 -> hi=0x12345678 next cycle, done pulse, busy=0.
//     - MTLO during a busy DIVU is ignored; DIVU result written normally.
//  6. Reset mid-operation: deassert reset_n 10 cycles into DIVU -> busy=0, hi=lo=0 immediately.
//     After release, MULTU 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (optional FAST_MULT_EN: single-cycle multiply)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc;      // mul: {carry, upper, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   md;       // multiplicand or divisor magnitude
  logic               is_div, neg_q, neg_r;

  logic               is_mul_op, is_div_op, iter_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH:0]   mul_next, div_sh, div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  // Operand decode: signedness and magnitudes for the iterative datapath
  always_comb begin
    is_mul_op = (fncode == F_MULT) || (fncode == F_MULTU);
    is_div_op = (fncode == F_DIV)  || (fncode == F_DIVU);
`ifdef FAST_MULT_EN
    iter_op   = is_div_op;
`else
    iter_op   = is_mul_op || is_div_op;
`endif
    a_neg = ~fncode[0] & op_a[WIDTH-1];
    b_neg = ~fncode[0] & op_b[WIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

`ifdef FAST_MULT_EN
  // Single-cycle product; signed form sign-extends both operands to 2*WIDTH
  always_comb begin
    if (fncode == F_MULT)
      fast_prod = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
    else
      fast_prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  end
`endif

  // One shift-add or restoring-subtract step, plus final sign correction
  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, md} : {(WIDTH+1){1'b0}});
    mul_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};
    div_sh    = {acc[2*WIDTH-1:0], 1'b0};
    div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, md};
    div_next  = div_trial[WIDTH] ? div_sh : {div_trial, div_sh[WIDTH-1:1], 1'b1};
    prod_fix  = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: iterative ops run WIDTH steps then one fix-up cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && iter_op) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      md     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (fncode == F_MTHI) begin
            hi   <= op_a;
            done <= 1'b1;
          end else if (fncode == F_MTLO) begin
            lo   <= op_a;
            done <= 1'b1;
`ifdef FAST_MULT_EN
          end else if (is_mul_op) begin
            {hi, lo} <= fast_prod;
            done     <= 1'b1;
`endif
          end else if (iter_op) begin
            cnt    <= CW'(WIDTH);
            is_div <= is_div_op;
            neg_r  <= is_div_op & a_neg;
            // A zero divisor keeps the all-ones quotient unsigned-looking
            neg_q  <= (a_neg ^ b_neg) & ~(is_div_op && op_b == '0);
            if (is_div_op) begin
              md  <= b_mag;
              acc <= {{(WIDTH+1){1'b0}}, a_mag};
            end else begin
              md  <= a_mag;
              acc <= {{(WIDTH+1){1'b0}}, b_mag};
            end
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
